// File: rtl/mips_mem_sys.sv
// Unified instruction/data memory for the multicycle MIPS core.
// Includes a boot-load port, one MMIO output register and a sticky misalignment fault.
module mips_mem_sys #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] MMIO_ADDR = 32'h0000_FFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iord,
    input  logic        memwrite,
    input  logic        irwrite,
    input  logic [31:0] pc,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] instr,
    output logic [31:0] readdata,
    input  logic        boot_valid,
    input  logic [31:0] boot_addr,
    input  logic [31:0] boot_data,
    input  logic        boot_done,
    output logic        boot_ready,
    output logic        cpu_reset,
    output logic [31:0] mmio_out,
    output logic        mmio_valid,
    output logic        fault,
    output logic [31:0] fetch_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] ram [DEPTH];
    logic [31:0] instr_q, instr_d;
    logic [31:0] mmio_q, mmio_d;
    logic [31:0] fetch_q, fetch_d;
    logic        mmio_valid_q, mmio_valid_d;

    logic [31:0]   addr;
    logic [AW-1:0] idx, boot_idx, wr_idx;
    logic [31:0]   wr_data;
    logic          is_mmio, aligned, ram_we;
    logic          unused_boot_bits;

    assign addr     = iord ? aluout : pc;
    assign idx      = addr[AW+1:2];
    assign boot_idx = boot_addr[AW+1:2];
    assign is_mmio  = (addr == MMIO_ADDR);
    assign aligned  = (addr[1:0] == 2'b00);
    assign readdata = is_mmio ? mmio_q : ram[idx];

    // Upper and byte-offset boot address bits are deliberately ignored.
    assign unused_boot_bits = ^{boot_addr[31:AW+2], boot_addr[1:0]};

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        mmio_d       = mmio_q;
        fetch_d      = fetch_q;
        mmio_valid_d = 1'b0;
        ram_we       = 1'b0;
        wr_idx       = idx;
        wr_data      = writedata;
        case (state_q)
            BOOT: begin
                if (boot_valid) begin
                    ram_we  = 1'b1;
                    wr_idx  = boot_idx;
                    wr_data = boot_data;
                end
                if (boot_done)
                    state_d = RUN;
            end
            RUN: begin
                if ((irwrite || memwrite) && !aligned) begin
                    state_d = FAULT;
                end else begin
                    // readdata is the pre-write value, giving read-before-write on a combined strobe.
                    if (irwrite) begin
                        instr_d = readdata;
                        fetch_d = fetch_q + 32'd1;
                    end
                    if (memwrite) begin
                        if (is_mmio) begin
                            mmio_d       = writedata;
                            mmio_valid_d = 1'b1;
                        end else begin
                            ram_we = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BOOT;
            instr_q      <= '0;
            mmio_q       <= '0;
            fetch_q      <= '0;
            mmio_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            mmio_q       <= mmio_d;
            fetch_q      <= fetch_d;
            mmio_valid_q <= mmio_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we && !reset)
            ram[wr_idx] <= wr_data;
    end

    assign instr       = instr_q;
    assign mmio_out    = mmio_q;
    assign mmio_valid  = mmio_valid_q;
    assign fetch_count = fetch_q;
    assign boot_ready  = (state_q == BOOT);
    assign cpu_reset   = (state_q != RUN);
    assign fault       = (state_q == FAULT);
endmodule

// File: tb/tb_mips_mem_sys.sv
// Randomized plus directed bench for mips_mem_sys against a word-array reference model.
module tb_mips_mem_sys;
    localparam int          DEPTH = 256;
    localparam logic [31:0] MMIO  = 32'h0000_FFFC;

    logic        clk = 1'b0;
    logic        reset, iord, memwrite, irwrite, boot_valid, boot_done;
    logic [31:0] pc, aluout, writedata, boot_addr, boot_data;
    logic [31:0] instr, readdata, mmio_out, fetch_count;
    logic        boot_ready, cpu_reset, mmio_valid, fault;

    mips_mem_sys #(.DEPTH(DEPTH), .MMIO_ADDR(MMIO)) dut (
        .clk(clk), .reset(reset), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pc(pc), .aluout(aluout), .writedata(writedata), .instr(instr), .readdata(readdata),
        .boot_valid(boot_valid), .boot_addr(boot_addr), .boot_data(boot_data),
        .boot_done(boot_done), .boot_ready(boot_ready), .cpu_reset(cpu_reset),
        .mmio_out(mmio_out), .mmio_valid(mmio_valid), .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: mode 0=loading, 1=running, 2=faulted.
    logic [31:0] m_ram [DEPTH];
    logic [31:0] m_instr, m_mmio, m_fc;
    logic        m_mv;
    int          m_mode;
    bit          model_on = 0;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return (a == MMIO) ? m_mmio : m_ram[widx(a)];
    endfunction

    initial for (int i = 0; i < DEPTH; i++) m_ram[i] = 'x;

    always @(posedge clk) begin
        logic [31:0] a, old;
        a = iord ? aluout : pc;
        if (reset) begin
            model_on = 1;
            m_mode = 0; m_instr = 0; m_mmio = 0; m_fc = 0; m_mv = 0;
        end else if (model_on) begin
            m_mv = 0;
            if (m_mode == 0) begin
                if (boot_valid) m_ram[widx(boot_addr)] = boot_data;
                if (boot_done) m_mode = 1;
            end else if (m_mode == 1) begin
                if ((irwrite || memwrite) && a[1:0] != 2'b00) begin
                    m_mode = 2;
                end else begin
                    old = m_read(a);
                    if (irwrite) begin
                        m_instr = old;
                        m_fc = m_fc + 1;
                    end
                    if (memwrite) begin
                        if (a == MMIO) begin
                            m_mmio = writedata;
                            m_mv = 1;
                        end else begin
                            m_ram[widx(a)] = writedata;
                        end
                    end
                end
            end
        end
    end

    // Compare process: every output against the model, each cycle.
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        if (model_on) begin
            if (!$isunknown(m_instr)) chk("instr", instr, m_instr);
            chk("fetch_count", fetch_count, m_fc);
            chk("mmio_out", mmio_out, m_mmio);
            chk("mmio_valid", {31'd0, mmio_valid}, {31'd0, m_mv});
            chk("fault", {31'd0, fault}, {31'd0, m_mode == 2});
            chk("boot_ready", {31'd0, boot_ready}, {31'd0, m_mode == 0});
            chk("cpu_reset", {31'd0, cpu_reset}, {31'd0, m_mode != 1});
            exp_rd = m_read(iord ? aluout : pc);
            if (!$isunknown(exp_rd)) chk("readdata", readdata, exp_rd);
        end
    end

    task automatic idle();
        reset = 0; iord = 0; memwrite = 0; irwrite = 0; pc = 0; aluout = 0; writedata = 0;
        boot_valid = 0; boot_addr = 0; boot_data = 0; boot_done = 0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 199);
        if (r < 12) return MMIO;
        if (r < 14) return ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
        if (r < 40) return $urandom() & 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 31)) << 2;
    endfunction

    task automatic rand_inputs(input bit boot_phase);
        iord = 1'($urandom); pc = rnd_addr(); aluout = rnd_addr();
        memwrite = ($urandom_range(0, 2) == 0); irwrite = ($urandom_range(0, 2) == 0);
        writedata = $urandom();
        boot_valid = boot_phase ? 1'b1 : 1'($urandom);
        boot_addr = $urandom(); boot_data = $urandom();
        boot_done = boot_phase ? 1'b0 : 1'($urandom);
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        // Randomized episodes; the first one fills every RAM word.
        for (int ep = 0; ep < 6; ep++) begin
            idle(); reset = 1; step();
            reset = 0;
            for (int w = 0; w < ((ep == 0) ? DEPTH : 20); w++) begin
                rand_inputs(1'b1);
                boot_addr = (ep == 0) ? 32'(w) << 2 | ($urandom() & 32'hFFFF_0003) : $urandom();
                step();
            end
            idle(); boot_done = 1; step();
            for (int c = 0; c < 250; c++) begin
                rand_inputs(1'b0);
                step();
            end
        end

        // Directed scenarios with literal expectations.
        idle(); reset = 1; step();
        chk("rst_instr", instr, 32'h0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_boot_ready", {31'd0, boot_ready}, 32'd1);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_fetch", fetch_count, 32'd0);
        chk("rst_mmio", mmio_out, 32'd0);
        reset = 0;
        boot_valid = 1; boot_addr = 32'h0; boot_data = 32'h2008_0005; step();
        boot_addr = 32'h4; boot_data = 32'h2009_000C; boot_done = 1; step();
        boot_valid = 0; boot_done = 0;
        chk("boot_ready_fall", {31'd0, boot_ready}, 32'd0);
        chk("cpu_reset_fall", {31'd0, cpu_reset}, 32'd0);
        iord = 0; pc = 32'h4; irwrite = 1; step();
        irwrite = 0;
        chk("fetch_instr", instr, 32'h2009_000C);
        chk("fetch_count1", fetch_count, 32'd1);

        iord = 1; aluout = 32'h40; memwrite = 1; writedata = 32'hDEAD_BEEF; step();
        memwrite = 0; #1;
        chk("store_read", readdata, 32'hDEAD_BEEF);
        aluout = 32'h440; memwrite = 1; writedata = 32'hCAFE_F00D; step();
        memwrite = 0; aluout = 32'h40; #1;
        chk("wrap_read", readdata, 32'hCAFE_F00D);

        aluout = 32'h3FFC; memwrite = 1; writedata = 32'hA5A5_A5A5; step();
        aluout = MMIO; writedata = 32'h7; step();
        memwrite = 0;
        chk("mmio_out", mmio_out, 32'h7);
        chk("mmio_valid_hi", {31'd0, mmio_valid}, 32'd1);
        chk("mmio_read", readdata, 32'h7);
        aluout = 32'h3FFC; #1;
        chk("mmio_ram_alias", readdata, 32'hA5A5_A5A5);
        step();
        chk("mmio_valid_lo", {31'd0, mmio_valid}, 32'd0);

        aluout = 32'h10; memwrite = 1; writedata = 32'h1111_1111; step();
        irwrite = 1; writedata = 32'h2222_2222; step();
        memwrite = 0; irwrite = 0;
        chk("rbw_instr", instr, 32'h1111_1111);
        chk("rbw_fetch", fetch_count, 32'd2);
        chk("rbw_read", readdata, 32'h2222_2222);

        aluout = 32'h42; memwrite = 1; writedata = 32'h99; step();
        memwrite = 0;
        chk("fault_set", {31'd0, fault}, 32'd1);
        chk("fault_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        aluout = 32'h40; #1;
        chk("fault_no_write", readdata, 32'hCAFE_F00D);
        aluout = 32'h10; irwrite = 1; memwrite = 1; writedata = 32'h0; step();
        irwrite = 0; memwrite = 0;
        chk("fault_hold_instr", instr, 32'h1111_1111);
        chk("fault_hold_fetch", fetch_count, 32'd2);
        chk("fault_no_store", readdata, 32'h2222_2222);
        reset = 1; step();
        reset = 0;
        chk("fault_clear", {31'd0, fault}, 32'd0);
        chk("fault_to_boot", {31'd0, boot_ready}, 32'd1);

        boot_valid = 1; boot_addr = 32'h80; boot_data = 32'h55AA_55AA; step();
        boot_valid = 0; reset = 1; step();
        reset = 0;
        chk("midboot_ready", {31'd0, boot_ready}, 32'd1);
        chk("midboot_fetch", fetch_count, 32'd0);
        iord = 1; aluout = 32'h80; #1;
        chk("midboot_persist", readdata, 32'h55AA_55AA);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mips_mem_sys.md
Name: mips_mem_sys

Overview:
- Unified instruction/data memory subsystem directly downstream of the multicycle `mips` core.
- Consumes the core's `iord`, `memwrite`, `irwrite`, `pc`, `aluout` and `writedata`. Produces `instr` (instruction register) and `readdata`.
- Adds a boot-load port that fills RAM while the core is held in reset, plus one memory-mapped output register.
- Adds a sticky misalignment fault that freezes the core.

Parameters:
- DEPTH, 256, RAM size in 32-bit words; power of two.
- MMIO_ADDR, 32'h0000_FFFC, byte address of the output register; excluded from RAM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- iord  in  1  core address select: 1 selects `aluout`, 0 selects `pc`.
- memwrite  in  1  core store strobe.
- irwrite  in  1  core instruction-register load strobe.
- pc  in  32  core program counter, byte address.
- aluout  in  32  core data address, byte address.
- writedata  in  32  core store data.
- instr  out  32  instruction register, to core.
- readdata  out  32  combinational read data, to core.
- boot_valid  in  1  boot write request.
- boot_addr  in  32  boot byte address, word-aligned.
- boot_data  in  32  boot write data.
- boot_done  in  1  one-cycle pulse: loading complete.
- boot_ready  out  1  high while boot writes are accepted.
- cpu_reset  out  1  reset to core; high in BOOT and FAULT.
- mmio_out  out  32  last value stored to MMIO_ADDR.
- mmio_valid  out  1  one-cycle pulse when `mmio_out` is updated.
- fault  out  1  sticky misaligned-access flag.
- fetch_count  out  32  number of accepted `irwrite` strobes.

Behaviour:
- States: BOOT, RUN, FAULT. Reset enters BOOT.
- Reset values: instr=0, mmio_out=0, mmio_valid=0, fault=0, fetch_count=0, boot_ready=1, cpu_reset=1. RAM contents are not reset.
- Address: addr = iord ? aluout : pc. Word index = addr[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words. The exception is an exact match to MMIO_ADDR.
- readdata: combinational, zero latency.
  - Returns mmio_out when addr==MMIO_ADDR.
  - Otherwise returns RAM[index].
  - Valid in all states.
- BOOT:
  - boot_ready=1, cpu_reset=1. Core strobes are ignored.
  - boot_valid writes RAM[boot_addr index] <= boot_data at the clock edge. boot_addr[1:0] is ignored.
  - boot_done moves to RUN next cycle. A boot_valid in the same cycle still commits.
- RUN: boot_ready=0, cpu_reset=0. Boot inputs are ignored.
  - irwrite with addr[1:0]==0: instr <= RAM[index] (or mmio_out at MMIO_ADDR) at the edge; fetch_count += 1, wrapping at 2^32.
  - memwrite with addr[1:0]==0 and addr!=MMIO_ADDR: RAM[index] <= writedata at the edge.
  - memwrite with addr[1:0]==0 and addr==MMIO_ADDR: mmio_out <= writedata; mmio_valid=1 for exactly the next cycle. RAM is untouched.
  - memwrite and irwrite in the same cycle: instr captures pre-write data (read-before-write). The write commits.
  - Misaligned access: irwrite or memwrite with addr[1:0]!=0 goes to FAULT next cycle. The strobe's effect is suppressed: no RAM write, no instr load, no count.
  - Plain reads (no strobe) never fault.
- FAULT: fault=1, cpu_reset=1, boot_ready=0. All inputs are ignored. Only reset exits.
- mmio_valid defaults to 0 in every cycle without a qualifying store.
- instr, fetch_count and mmio_out hold their values across state changes until reset.
- Reset asserted in any state, including mid-boot: all outputs return to reset values next edge and the state returns to BOOT. Completed RAM writes persist.

Test Plan:
- Reset, then boot writes 0x20080005 to addr 0 and 0x2009000C to addr 4, then boot_done → boot_ready falls and cpu_reset falls next cycle. iord=0, pc=4, irwrite=1 → instr=0x2009000C, fetch_count=1.
- RUN, iord=1, aluout=0x40, memwrite=1, writedata=0xDEADBEEF → next cycle readdata=0xDEADBEEF with aluout=0x40. Same write with aluout=0x440 (DEPTH=256, wraps) → readdata at 0x40 also reads it.
- memwrite to 0xFFFC with writedata=0x7 → mmio_out=0x7, mmio_valid high for exactly one cycle, RAM[0x3FFC index] unchanged. Read of 0xFFFC → readdata=0x7.
- RAM[0x10]=0x11111111; memwrite 0x22222222 and irwrite both to 0x10 in the same cycle → instr=0x11111111, then readdata=0x22222222.
- iord=1, aluout=0x42, memwrite=1 → no RAM change, next cycle fault=1 and cpu_reset=1. Later strobes are ignored. Reset → BOOT, fault=0.
- Reset pulsed mid-boot after one write → state BOOT and fetch_count=0; the earlier boot word is still readable via readdata.
